// File: rtl/fpu_issue_ctrl_if.sv
// Issue/writeback handshake between the EX stage and the FPU issue controller.
// Signal names follow the existing pipeline netlist, so fpuOp keeps its mixed case.
interface fpu_issue_ctrl_if;
    logic       fpu_sel;
    logic [3:0] fpuOp;
    logic [4:0] rd;
    logic       flush;
    logic       stall;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       busy;

    modport master (
        output fpu_sel, fpuOp, rd, flush,
        input  stall, wb_valid, wb_rd, busy
    );

    modport slave (
        input  fpu_sel, fpuOp, rd, flush,
        output stall, wb_valid, wb_rd, busy
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: stalls EX for a fixed per-op latency, then presents the writeback.
// Optional stall-cycle performance counter is enabled by defining FPU_ISSUE_CTRL_PERF_EN.
module fpu_issue_ctrl #(
    parameter int unsigned LAT_ADD  = 7,
    parameter int unsigned LAT_MUL  = 5,
    parameter int unsigned LAT_DIV  = 6,
    parameter int unsigned LAT_CMP  = 1,
    parameter int unsigned LAT_SQRT = 16,
    parameter int unsigned LAT_CVT  = 6
) (
    input  logic              clock,
    input  logic              clear,
    fpu_issue_ctrl_if.slave   bus,
    output logic [31:0]       stall_cycles
);
    localparam int unsigned CNT_W = 5;
    localparam int unsigned RD_W  = 5;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]  lat;
    logic              accept;
    logic              stall_c;
    logic              wb_valid_c;
    logic [RD_W-1:0]   wb_rd_c;

    function automatic logic [CNT_W-1:0] op_latency(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001: op_latency = CNT_W'(LAT_ADD);
            4'b0010:          op_latency = CNT_W'(LAT_MUL);
            4'b0011:          op_latency = CNT_W'(LAT_DIV);
            4'b0101, 4'b0111: op_latency = CNT_W'(LAT_CMP);
            4'b0110:          op_latency = CNT_W'(LAT_SQRT);
            4'b1000, 4'b1001: op_latency = CNT_W'(LAT_CVT);
            default:          op_latency = '0;
        endcase
    endfunction

    assign lat    = op_latency(bus.fpuOp);
    assign accept = (state_q == IDLE) && bus.fpu_sel && !bus.flush;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
        end
    end

    // BUSY covers cycles T+1..T+L-1, so the counter is loaded with L-2 on issue.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        stall_c    = 1'b0;
        wb_valid_c = 1'b0;
        wb_rd_c    = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (lat == '0) begin
                        wb_valid_c = 1'b1;
                        wb_rd_c    = bus.rd;
                    end else begin
                        stall_c = 1'b1;
                        rd_d    = bus.rd;
                        if (lat == CNT_W'(1)) begin
                            state_d = DONE;
                        end else begin
                            state_d = BUSY;
                            cnt_d   = lat - CNT_W'(2);
                        end
                    end
                end
            end
            BUSY: begin
                wb_rd_c = rd_q;
                if (bus.flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    stall_c = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                wb_rd_c    = rd_q;
                wb_valid_c = !bus.flush;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, even if EX presents a request.
    assign bus.stall    = clear & stall_c;
    assign bus.wb_valid = clear & wb_valid_c;
    assign bus.wb_rd    = clear ? wb_rd_c : '0;
    assign bus.busy     = (state_q != IDLE);

`ifdef FPU_ISSUE_CTRL_PERF_EN
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            stall_cycles <= '0;
        end else if (stall_c && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl.
module tb_fpu_issue_ctrl;
    logic        clk;
    logic        clear;
    logic [31:0] stall_cycles;
    int          checks;
    int          failures;
    int          n;

    fpu_issue_ctrl_if bus();

    fpu_issue_ctrl dut (
        .clock        (clk),
        .clear        (clear),
        .bus          (bus.slave),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        clear        = 1'b0;
        bus.fpu_sel  = 1'b1;
        bus.fpuOp    = 4'b0000;
        bus.rd       = 5'd31;
        bus.flush    = 1'b0;

        // Reset held with a live request: everything quiet.
        repeat (2) tick();
        settle();
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_wbv", 32'(bus.wb_valid), 32'd0);
        check("rst_wbrd", 32'(bus.wb_rd), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cnt", stall_cycles, 32'd0);

        tick();
        clear       = 1'b1;
        bus.fpu_sel = 1'b0;
        settle();
        check("idle_stall", 32'(bus.stall), 32'd0);
        check("idle_wbv", 32'(bus.wb_valid), 32'd0);

        // Add, rd=5: stall T..T+6, writeback at T+7.
        tick();
        bus.fpu_sel = 1'b1;
        bus.fpuOp   = 4'b0000;
        bus.rd      = 5'd5;
        for (int i = 0; i <= 7; i++) begin
            if (i > 0) tick();
            settle();
            check($sformatf("add_stall_%0d", i), 32'(bus.stall), (i < 7) ? 32'd1 : 32'd0);
            check($sformatf("add_wbv_%0d", i), 32'(bus.wb_valid), (i == 7) ? 32'd1 : 32'd0);
        end
        check("add_wbrd", 32'(bus.wb_rd), 32'd5);
        tick();
        bus.fpu_sel = 1'b0;
        settle();
        check("add_after_busy", 32'(bus.busy), 32'd0);

        // Sign-inject, rd=9: zero latency, same-cycle writeback.
        tick();
        bus.fpu_sel = 1'b1;
        bus.fpuOp   = 4'b0100;
        bus.rd      = 5'd9;
        settle();
        check("sgnj_wbv", 32'(bus.wb_valid), 32'd1);
        check("sgnj_wbrd", 32'(bus.wb_rd), 32'd9);
        check("sgnj_stall", 32'(bus.stall), 32'd0);
        tick();
        bus.fpu_sel = 1'b0;
        settle();
        check("sgnj_busy", 32'(bus.busy), 32'd0);
        check("sgnj_wbv_next", 32'(bus.wb_valid), 32'd0);

        // Sqrt (rd=3) then compare (rd=4) back-to-back.
        tick();
        bus.fpu_sel = 1'b1;
        bus.fpuOp   = 4'b0110;
        bus.rd      = 5'd3;
        for (int i = 0; i <= 18; i++) begin
            if (i > 0) tick();
            if (i == 17) begin
                bus.fpuOp = 4'b0111;
                bus.rd    = 5'd4;
            end
            settle();
            check($sformatf("b2b_stall_%0d", i), 32'(bus.stall),
                  (i == 16 || i == 18) ? 32'd0 : 32'd1);
            check($sformatf("b2b_wbv_%0d", i), 32'(bus.wb_valid),
                  (i == 16 || i == 18) ? 32'd1 : 32'd0);
            if (i == 16) check("b2b_wbrd_sqrt", 32'(bus.wb_rd), 32'd3);
            if (i == 18) check("b2b_wbrd_cmp", 32'(bus.wb_rd), 32'd4);
        end
        tick();
        bus.fpu_sel = 1'b0;
        settle();
        check("b2b_busy", 32'(bus.busy), 32'd0);

        // Divide killed by flush at T+3; compare accepted at T+4.
        tick();
        bus.fpu_sel = 1'b1;
        bus.fpuOp   = 4'b0011;
        bus.rd      = 5'd7;
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) tick();
            if (i == 3) bus.flush = 1'b1;
            settle();
            check($sformatf("div_stall_%0d", i), 32'(bus.stall), (i < 3) ? 32'd1 : 32'd0);
            check($sformatf("div_wbv_%0d", i), 32'(bus.wb_valid), 32'd0);
        end
        tick();
        bus.flush = 1'b0;
        bus.fpuOp = 4'b0101;
        bus.rd    = 5'd12;
        settle();
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_new_stall", 32'(bus.stall), 32'd1);
        check("flush_new_wbv", 32'(bus.wb_valid), 32'd0);
        tick();
        settle();
        check("flush_new_done_wbv", 32'(bus.wb_valid), 32'd1);
        check("flush_new_done_wbrd", 32'(bus.wb_rd), 32'd12);
        check("flush_new_done_stall", 32'(bus.stall), 32'd0);
        tick();
        bus.fpu_sel = 1'b0;
        settle();

        // Multiply interrupted by a one-cycle reset pulse at T+2.
        tick();
        bus.fpu_sel = 1'b1;
        bus.fpuOp   = 4'b0010;
        bus.rd      = 5'd17;
        settle();
        check("mul_stall_t0", 32'(bus.stall), 32'd1);
        tick();
        settle();
        check("mul_busy_t1", 32'(bus.busy), 32'd1);
        tick();
        clear = 1'b0;
        settle();
        check("mulrst_stall", 32'(bus.stall), 32'd0);
        check("mulrst_wbv", 32'(bus.wb_valid), 32'd0);
        check("mulrst_wbrd", 32'(bus.wb_rd), 32'd0);
        check("mulrst_busy", 32'(bus.busy), 32'd0);
        check("mulrst_cnt", stall_cycles, 32'd0);
        tick();
        clear       = 1'b1;
        bus.fpu_sel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            settle();
            check($sformatf("mulrst_post_wbv_%0d", i), 32'(bus.wb_valid), 32'd0);
        end

        // Add then sqrt back-to-back for the stall counter.
        tick();
        bus.fpu_sel = 1'b1;
        bus.fpuOp   = 4'b0000;
        bus.rd      = 5'd1;
        settle();
        n = 0;
        while (!bus.wb_valid && n < 30) begin
            tick();
            settle();
            n++;
        end
        check("perf_add_lat", 32'(n), 32'd7);
        tick();
        bus.fpuOp = 4'b0110;
        bus.rd    = 5'd2;
        settle();
        n = 0;
        while (!bus.wb_valid && n < 30) begin
            tick();
            settle();
            n++;
        end
        check("perf_sqrt_lat", 32'(n), 32'd16);
        tick();
        bus.fpu_sel = 1'b0;
        settle();
`ifdef FPU_ISSUE_CTRL_PERF_EN
        check("perf_stall_cycles", stall_cycles, 32'd23);
`else
        check("perf_stall_cycles", stall_cycles, 32'd0);
`endif

        // Flush while idle: nothing accepted.
        tick();
        bus.fpu_sel = 1'b1;
        bus.fpuOp   = 4'b0000;
        bus.flush   = 1'b1;
        settle();
        check("idleflush_stall", 32'(bus.stall), 32'd0);
        check("idleflush_wbv", 32'(bus.wb_valid), 32'd0);
        tick();
        bus.flush   = 1'b0;
        bus.fpu_sel = 1'b0;
        settle();
        check("idleflush_busy", 32'(bus.busy), 32'd0);

        // Flush in DONE masks the writeback.
        tick();
        bus.fpu_sel = 1'b1;
        bus.fpuOp   = 4'b0101;
        bus.rd      = 5'd2;
        settle();
        check("doneflush_stall", 32'(bus.stall), 32'd1);
        tick();
        bus.flush = 1'b1;
        settle();
        check("doneflush_busy", 32'(bus.busy), 32'd1);
        check("doneflush_wbv", 32'(bus.wb_valid), 32'd0);
        tick();
        bus.flush   = 1'b0;
        bus.fpu_sel = 1'b0;
        settle();
        check("doneflush_idle", 32'(bus.busy), 32'd0);
        check("doneflush_wbv_after", 32'(bus.wb_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
